// File: rtl/ps2_key_sender_if.sv
// Key event handshake between a scancode source and the PS/2 sender.
// One event moves on each cycle with key_valid and ready both high.
interface ps2_key_sender_if;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_release;
    logic       key_extended;
    logic       ready;

    modport master (
        output key_valid, key_code, key_release, key_extended,
        input  ready
    );

    modport slave (
        input  key_valid, key_code, key_release, key_extended,
        output ready
    );
endinterface

// File: rtl/ps2_key_sender.sv
// PS/2 device-to-host keyboard transmitter on open-drain clk/data pins.
// Sends the [E0] [F0] code sequence for each accepted key event.
module ps2_key_sender #(
    parameter int CLK_HZ   = 25_000_000,
    parameter int PS2_HZ   = 12_500,
    parameter int BUS_IDLE = 100,
    parameter int GAP      = 2000
) (
    input  logic clk,
    input  logic n_reset,
    ps2_key_sender_if.slave key,
    output logic ps2clk_o,
    output logic ps2data_o,
    input  logic ps2clk_i,
    output logic byte_done
);
    localparam int H    = CLK_HZ / (2 * PS2_HZ);
    localparam int M1   = (H > BUS_IDLE) ? H : BUS_IDLE;
    localparam int CMAX = (M1 > GAP) ? M1 : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] H_LAST   = CW'(H - 1);
    localparam logic [CW-1:0] H_CHK    = CW'(H - H / 2);
    localparam logic [CW-1:0] IDLE_N   = CW'(BUS_IDLE);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_HI, S_LO, S_GAP
    } state_t;

    state_t          state, state_n;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_idx;
    logic [1:0]      byte_idx;
    logic [1:0]      last_idx;
    logic [2:0][7:0] seq;
    logic            done_q;
    logic [7:0]      cur_byte;
    logic [2:0]      dsel;
    logic            cur_bit;
    logic            bus_hi;
    logic            accept;
    logic            half_end;
    logic            inhibit;
    logic            last_bit;
    logic            last_byte;

    assign bus_hi    = sync_q[1];
    assign accept    = key.key_valid && (state == S_IDLE);
    assign half_end  = (cnt == H_LAST);
    assign last_bit  = (bit_idx == 4'd10);
    assign last_byte = (byte_idx == last_idx);
    // Early BIT_HI cycles are skipped: the synchroniser still shows our own low.
    assign inhibit   = (state == S_HI) && (cnt >= H_CHK) && !bus_hi;
    assign dsel      = bit_idx[2:0] - 3'd1;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (accept) state_n = S_WAIT;
            S_WAIT: if (bus_hi && cnt == IDLE_N) state_n = S_HI;
            S_HI: begin
                if (inhibit)       state_n = S_WAIT;
                else if (half_end) state_n = S_LO;
            end
            S_LO: begin
                if (half_end) begin
                    if (!last_bit)      state_n = S_HI;
                    else if (last_byte) state_n = S_IDLE;
                    else                state_n = S_GAP;
                end
            end
            S_GAP: if (cnt == GAP_LAST) state_n = S_WAIT;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_q   <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            last_idx <= '0;
            seq      <= '0;
            done_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ps2clk_i};
            done_q <= (state == S_LO) && half_end && last_bit;
            if (state_n != state || state == S_IDLE ||
                (state == S_WAIT && !bus_hi)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state_n == S_WAIT) begin
                bit_idx <= '0;
            end else if (state == S_LO && state_n == S_HI) begin
                bit_idx <= bit_idx + 4'd1;
            end
            if (accept) begin
                byte_idx <= '0;
                seq[0]   <= key.key_extended ? 8'hE0 :
                            key.key_release  ? 8'hF0 : key.key_code;
                seq[1]   <= (key.key_extended && key.key_release) ?
                            8'hF0 : key.key_code;
                seq[2]   <= key.key_code;
                last_idx <= {1'b0, key.key_extended} +
                            {1'b0, key.key_release};
            end else if (state == S_GAP && state_n == S_WAIT) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    always_comb begin
        unique case (byte_idx)
            2'd0:    cur_byte = seq[0];
            2'd1:    cur_byte = seq[1];
            default: cur_byte = seq[2];
        endcase
    end

    always_comb begin
        cur_bit = 1'b1;
        unique case (1'b1)
            bit_idx == 4'd0:  cur_bit = 1'b0;
            bit_idx == 4'd9:  cur_bit = ~^cur_byte;
            bit_idx >= 4'd10: cur_bit = 1'b1;
            default:          cur_bit = cur_byte[dsel];
        endcase
    end

    always_comb begin
        key.ready = (state == S_IDLE);
        ps2clk_o  = (state != S_LO);
        ps2data_o = (state == S_HI || state == S_LO) ? cur_bit : 1'b1;
        byte_done = done_q;
    end
endmodule

// File: tb/tb_ps2_key_sender.sv
// Bench for ps2_key_sender: host-side frame decoder plus scancode model.
// Randomised key events are compared against the expected byte stream.
module tb_ps2_key_sender;
    localparam int CLK_HZ   = 1000;
    localparam int PS2_HZ   = 50;
    localparam int BUS_IDLE = 5;
    localparam int GAP      = 40;
    localparam int H        = CLK_HZ / (2 * PS2_HZ);

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic host_low = 1'b0;
    logic ps2clk_o, ps2data_o, ps2clk_i, byte_done;

    ps2_key_sender_if kif();

    assign ps2clk_i = ps2clk_o & ~host_low;

    ps2_key_sender #(
        .CLK_HZ(CLK_HZ), .PS2_HZ(PS2_HZ),
        .BUS_IDLE(BUS_IDLE), .GAP(GAP)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .key(kif),
        .ps2clk_o(ps2clk_o),
        .ps2data_o(ps2data_o),
        .ps2clk_i(ps2clk_i),
        .byte_done(byte_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (kif.key_valid && kif.ready) acc_cnt <= acc_cnt + 1;
    end

    // Host model: samples data on each falling ps2clk_o and decodes frames.
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [10:0] sh;
    logic        pclk_d = 1'b1;
    int mon_err = 0, mon_falls = 0, mon_aborts = 0;
    int mon_nbits = 0, bd_cnt = 0, last_fall = 0;

    always @(negedge clk) begin
        if (byte_done === 1'b1) bd_cnt++;
        if (pclk_d === 1'b1 && ps2clk_o === 1'b0) begin
            if (mon_nbits > 0 && cyc - last_fall > 25) begin
                mon_aborts++;
                mon_nbits = 0;
            end else if (mon_nbits > 0 && cyc - last_fall != 2 * H) begin
                mon_err++;
            end
            mon_falls++;
            last_fall = cyc;
            sh[mon_nbits] = ps2data_o;
            mon_nbits++;
            if (mon_nbits == 11) begin
                if (sh[0] !== 1'b0 || sh[10] !== 1'b1 || (^sh[9:1]) !== 1'b1)
                    mon_err++;
                else
                    rx_q.push_back(sh[8:1]);
                mon_nbits = 0;
            end
        end
        pclk_d = ps2clk_o;
    end

    function automatic int push_expected(input logic [7:0] c,
                                         input bit r, input bit e);
        int n = 1;
        if (e) begin exp_q.push_back(8'hE0); n++; end
        if (r) begin exp_q.push_back(8'hF0); n++; end
        exp_q.push_back(c);
        return n;
    endfunction

    function automatic int busy_cycles(input int nbytes);
        return nbytes * (1 + BUS_IDLE + 22 * H) + (nbytes - 1) * GAP;
    endfunction

    function automatic bit rx_matches();
        if (rx_q.size() != exp_q.size()) return 1'b0;
        for (int i = 0; i < rx_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        step();
        rx_q.delete();
        exp_q.delete();
        bd_cnt = 0;
        mon_err = 0;
    endtask

    task automatic offer(input logic [7:0] c, input bit r, input bit e,
                         output int acc);
        bit ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (kif.ready === 1'b1) begin ok = 1'b1; break; end
            step();
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL offer_ready: ready=%b required 1", kif.ready);
        end
        kif.key_code = c;
        kif.key_release = r;
        kif.key_extended = e;
        kif.key_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        kif.key_valid = 1'b0;
    endtask

    task automatic wait_idle(output int low, output int ff, output bit to);
        int f0 = mon_falls;
        low = 0;
        ff = -1;
        to = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (ff < 0 && mon_falls != f0) ff = last_fall;
            if (kif.ready === 1'b1) begin to = 1'b0; break; end
            low++;
        end
        step();
        step();
    endtask

    task automatic test_reset();
        n_cmp++;
        if (kif.ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_ready: got %b required 1", kif.ready);
        end
        n_cmp++;
        if (ps2clk_o !== 1'b1) begin
            n_bad++; $display("FAIL rst_clk: got %b required 1", ps2clk_o);
        end
        n_cmp++;
        if (ps2data_o !== 1'b1) begin
            n_bad++; $display("FAIL rst_data: got %b required 1", ps2data_o);
        end
        n_cmp++;
        if (byte_done !== 1'b0) begin
            n_bad++; $display("FAIL rst_done: got %b required 0", byte_done);
        end
        step();
        n_reset = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_make();
        int acc, low, ff, n;
        bit to;
        clear_obs();
        n = push_expected(8'h32, 1'b0, 1'b0);
        offer(8'h32, 1'b0, 1'b0, acc);
        wait_idle(low, ff, to);
        n_cmp++;
        if (to || low !== busy_cycles(n)) begin
            n_bad++; $display("FAIL make_busy: got %0d required %0d", low, busy_cycles(n));
        end
        n_cmp++;
        if (ff - acc !== 1 + BUS_IDLE + H) begin
            n_bad++; $display("FAIL make_first_fall: got %0d required %0d", ff - acc, 1 + BUS_IDLE + H);
        end
        n_cmp++;
        if (!rx_matches()) begin
            n_bad++; $display("FAIL make_bytes: got %0d bytes first %h required 32", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx);
        end
        n_cmp++;
        if (bd_cnt !== n) begin
            n_bad++; $display("FAIL make_done: got %0d required %0d", bd_cnt, n);
        end
        n_cmp++;
        if (mon_err !== 0) begin
            n_bad++; $display("FAIL make_frame: got %0d frame errors required 0", mon_err);
        end
    endtask

    task automatic test_break_ext();
        int acc, low, ff, n;
        bit to;
        clear_obs();
        n = push_expected(8'h5A, 1'b1, 1'b1);
        offer(8'h5A, 1'b1, 1'b1, acc);
        wait_idle(low, ff, to);
        n_cmp++;
        if (to || low !== busy_cycles(n)) begin
            n_bad++; $display("FAIL brk_busy: got %0d required %0d", low, busy_cycles(n));
        end
        n_cmp++;
        if (!rx_matches()) begin
            n_bad++; $display("FAIL brk_bytes: got %0d bytes required 3 (E0 F0 5A)", rx_q.size());
        end
        n_cmp++;
        if (bd_cnt !== 3) begin
            n_bad++; $display("FAIL brk_done: got %0d required 3", bd_cnt);
        end
        n_cmp++;
        if (mon_err !== 0) begin
            n_bad++; $display("FAIL brk_frame: got %0d frame errors required 0", mon_err);
        end
    endtask

    task automatic test_inhibit();
        int acc, low, ff, n, ab0;
        bit to, found;
        clear_obs();
        ab0 = mon_aborts;
        found = 1'b0;
        n = push_expected(8'h5A, 1'b1, 1'b1);
        offer(8'h5A, 1'b1, 1'b1, acc);
        for (int i = 0; i < 3000; i++) begin
            step();
            if (rx_q.size() == 1 && mon_nbits == 4 && ps2clk_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL inh_reach: bit 4 of byte 2 seen=%b required 1", found);
        end
        repeat (2) step();
        host_low = 1'b1;
        repeat (30) step();
        n_cmp++;
        if (ps2clk_o !== 1'b1 || ps2data_o !== 1'b1) begin
            n_bad++; $display("FAIL inh_release: clk=%b data=%b required 1 1", ps2clk_o, ps2data_o);
        end
        host_low = 1'b0;
        wait_idle(low, ff, to);
        n_cmp++;
        if (to || !rx_matches()) begin
            n_bad++; $display("FAIL inh_bytes: got %0d bytes required %0d (E0 F0 5A)", rx_q.size(), n);
        end
        n_cmp++;
        if (bd_cnt !== 3) begin
            n_bad++; $display("FAIL inh_done: got %0d required 3", bd_cnt);
        end
        n_cmp++;
        if (mon_aborts - ab0 !== 1) begin
            n_bad++; $display("FAIL inh_abort: got %0d aborted frames required 1", mon_aborts - ab0);
        end
        n_cmp++;
        if (mon_err !== 0) begin
            n_bad++; $display("FAIL inh_frame: got %0d frame errors required 0", mon_err);
        end
    endtask

    task automatic test_prestart();
        int acc, low, ff, n, f0, rel;
        bit to;
        clear_obs();
        n = push_expected(8'h1C, 1'b0, 1'b0);
        offer(8'h1C, 1'b0, 1'b0, acc);
        host_low = 1'b1;
        f0 = mon_falls;
        repeat (200) step();
        n_cmp++;
        if (mon_falls !== f0) begin
            n_bad++; $display("FAIL pre_hold: got %0d falls required 0", mon_falls - f0);
        end
        @(posedge clk);
        #1;
        host_low = 1'b0;
        rel = cyc;
        wait_idle(low, ff, to);
        n_cmp++;
        if (to || ff - rel < 1 + BUS_IDLE + H || ff - rel > 4 + BUS_IDLE + H) begin
            n_bad++; $display("FAIL pre_delay: got %0d required %0d..%0d", ff - rel, 1 + BUS_IDLE + H, 4 + BUS_IDLE + H);
        end
        n_cmp++;
        if (!rx_matches() || bd_cnt !== n) begin
            n_bad++; $display("FAIL pre_bytes: got %0d bytes %0d done required %0d", rx_q.size(), bd_cnt, n);
        end
    endtask

    task automatic test_async_reset();
        int acc, low, ff, n;
        bit to, found;
        clear_obs();
        found = 1'b0;
        offer(8'h1C, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3000; i++) begin
            step();
            if (mon_nbits == 7 && ps2clk_o === 1'b0) begin found = 1'b1; break; end
        end
        #2;
        n_reset = 1'b0;
        #1;
        n_cmp++;
        if (!found || ps2clk_o !== 1'b1 || ps2data_o !== 1'b1) begin
            n_bad++; $display("FAIL ares_lines: seen=%b clk=%b data=%b required 1 1 1", found, ps2clk_o, ps2data_o);
        end
        n_cmp++;
        if (kif.ready !== 1'b1) begin
            n_bad++; $display("FAIL ares_ready: got %b required 1", kif.ready);
        end
        repeat (3) step();
        n_reset = 1'b1;
        repeat (30) step();
        n_cmp++;
        if (bd_cnt !== 0 || rx_q.size() !== 0) begin
            n_bad++; $display("FAIL ares_partial: got %0d done %0d bytes required 0 0", bd_cnt, rx_q.size());
        end
        n = push_expected(8'h1C, 1'b0, 1'b0);
        offer(8'h1C, 1'b0, 1'b0, acc);
        wait_idle(low, ff, to);
        n_cmp++;
        if (to || !rx_matches() || bd_cnt !== n) begin
            n_bad++; $display("FAIL ares_resend: got %0d bytes %0d done required %0d", rx_q.size(), bd_cnt, n);
        end
        n_cmp++;
        if (mon_err !== 0) begin
            n_bad++; $display("FAIL ares_frame: got %0d frame errors required 0", mon_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] c [3];
        bit r [3], e [3];
        int total, low, ff, a0;
        bit to, ok;
        clear_obs();
        total = 0;
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            c[k] = 8'($urandom_range(0, 255));
            r[k] = 1'($urandom_range(0, 1));
            e[k] = 1'($urandom_range(0, 1));
            total += push_expected(c[k], r[k], e[k]);
        end
        a0 = acc_cnt;
        kif.key_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            kif.key_code = c[k];
            kif.key_release = r[k];
            kif.key_extended = e[k];
            begin : wait_rdy
                for (int i = 0; i < 5000; i++) begin
                    if (kif.ready === 1'b1) disable wait_rdy;
                    step();
                end
                ok = 1'b0;
            end
            @(posedge clk);
            #1;
            kif.key_code = ~c[k];
            kif.key_release = ~r[k];
        end
        kif.key_valid = 1'b0;
        wait_idle(low, ff, to);
        n_cmp++;
        if (!ok || to || acc_cnt - a0 !== 3) begin
            n_bad++; $display("FAIL b2b_accepts: got %0d required 3", acc_cnt - a0);
        end
        n_cmp++;
        if (!rx_matches()) begin
            n_bad++; $display("FAIL b2b_bytes: got %0d bytes required %0d", rx_q.size(), total);
        end
        n_cmp++;
        if (bd_cnt !== total || mon_err !== 0) begin
            n_bad++; $display("FAIL b2b_done: got %0d done %0d errors required %0d 0", bd_cnt, mon_err, total);
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        bit r, e;
        int acc, low, ff, n;
        bit to;
        for (int k = 0; k < 6; k++) begin
            clear_obs();
            c = 8'($urandom_range(0, 255));
            r = 1'($urandom_range(0, 1));
            e = 1'($urandom_range(0, 1));
            n = push_expected(c, r, e);
            offer(c, r, e, acc);
            wait_idle(low, ff, to);
            n_cmp++;
            if (to || low !== busy_cycles(n)) begin
                n_bad++; $display("FAIL rnd_busy[%0d]: got %0d required %0d", k, low, busy_cycles(n));
            end
            n_cmp++;
            if (!rx_matches()) begin
                n_bad++; $display("FAIL rnd_bytes[%0d]: code %h r=%b e=%b got %0d bytes required %0d", k, c, r, e, rx_q.size(), n);
            end
            n_cmp++;
            if (bd_cnt !== n || mon_err !== 0) begin
                n_bad++; $display("FAIL rnd_done[%0d]: got %0d done %0d errors required %0d 0", k, bd_cnt, mon_err, n);
            end
        end
    endtask

    initial begin
        kif.key_valid = 1'b0;
        kif.key_code = 8'h00;
        kif.key_release = 1'b0;
        kif.key_extended = 1'b0;
        repeat (3) step();
        test_reset();
        test_make();
        test_break_ext();
        test_inhibit();
        test_prestart();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
